// File: rtl/ring_stop_pkg.sv
// Shared ring NoC types: packet payload, packet kinds, core ids and stop limits.
// Used by ring_stop and ring_eject_fifo.
package ring_stop_pkg;

  localparam int unsigned RING_MAX_STOPS     = 32;
  localparam int unsigned CACHE_LINE_BYTES   = 64;
  localparam int unsigned CORE_ID_W          = $clog2(RING_MAX_STOPS);
  localparam int unsigned RING_PACKET_KIND_W = 2;
  localparam int unsigned RING_ADDR_W        = 40;
  localparam int unsigned RING_DATA_W        = 64;

  typedef logic [CORE_ID_W-1:0] core_id_t;

  typedef enum logic [RING_PACKET_KIND_W-1:0] {
    PKT_SNOOP   = 2'd0,
    PKT_IPI     = 2'd1,
    PKT_L2_MISS = 2'd2,
    PKT_L2_FILL = 2'd3
  } ring_packet_kind_t;

  typedef struct packed {
    logic                      valid;
    ring_packet_kind_t         kind;
    core_id_t                  sender_id;
    logic [RING_MAX_STOPS-1:0] dest_vector;
    logic [RING_ADDR_W-1:0]    address;
    logic [RING_DATA_W-1:0]    data;
  } ring_packet;

  // Bit mask covering the stops that actually exist on a ring of num_stops.
  function automatic logic [RING_MAX_STOPS-1:0] stop_mask(input int unsigned num_stops);
    logic [RING_MAX_STOPS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < RING_MAX_STOPS; i++) begin
      if (i < num_stops) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ring_eject_fifo.sv
// Ejection FIFO for ring_stop: power-of-two depth, head exposed, synchronous reset.
// Pushes while full and pops while empty are ignored.
module ring_eject_fifo
  import ring_stop_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  ring_packet push_data,
  input  logic       pop,
  output ring_packet head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ring_packet           mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ring_stop.sv
// One ring NoC stop: 1-cycle pass-through, local ejection, injection into free slots.
// Optional statistics counters enabled with `define RING_STOP_STATS_EN.
module ring_stop
  import ring_stop_pkg::*;
#(
  parameter int unsigned STOP_ID     = 0,
  parameter int unsigned NUM_STOPS   = 4,
  parameter int unsigned EJECT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  ring_packet  packet,
  output logic        issuing,
  output logic        ready,
  input  ring_packet  ring_in,
  output ring_packet  ring_out,
  output logic        eject_valid,
  output ring_packet  eject_packet,
`ifdef RING_STOP_STATS_EN
  output logic [31:0] stat_injected,
  output logic [31:0] stat_ejected,
  output logic [31:0] stat_bypass_full,
  output logic [31:0] stat_wait_cycles,
`endif
  input  logic        eject_ack
);

  localparam logic [RING_MAX_STOPS-1:0] SELF_BIT  = RING_MAX_STOPS'(1) << STOP_ID;
  localparam logic [RING_MAX_STOPS-1:0] STOP_MASK = stop_mask(NUM_STOPS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t     state;
  logic       hit;
  logic       take;
  logic       slot_free;
  logic       inj_empty;
  logic       fifo_full;
  logic       fifo_empty;
  ring_packet fwd;
  ring_packet inj;
  ring_packet eject_data;

  // Slot result for the incoming packet: eject our copy if there is room.
  always_comb begin
    hit  = ring_in.valid & ((ring_in.dest_vector & SELF_BIT) != '0);
    take = hit & ~fifo_full;
    fwd  = ring_in;
    if (take) fwd.dest_vector = ring_in.dest_vector & ~SELF_BIT;
    if (fwd.dest_vector == '0) fwd.valid = 1'b0;
    slot_free = ~fwd.valid;

    eject_data             = ring_in;
    eject_data.dest_vector = SELF_BIT;
  end

  // Local packet stamped for injection; self and non-existent stops masked off.
  always_comb begin
    inj             = packet;
    inj.valid       = 1'b1;
    inj.sender_id   = core_id_t'(STOP_ID);
    inj.dest_vector = packet.dest_vector & STOP_MASK & ~SELF_BIT;
    inj_empty       = (inj.dest_vector == '0);
  end

  assign issuing = ~reset & issue & slot_free;
  assign ready   = reset | ((state != S_WAIT) & ~issuing);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ring_out <= '0;
    end else begin
      ring_out <= (issuing & ~inj_empty) ? inj : fwd;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (issuing)    state <= S_DONE;
          else if (issue) state <= S_WAIT;
        end
        S_WAIT: begin
          if (issuing) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  ring_eject_fifo #(
    .DEPTH (EJECT_DEPTH)
  ) u_eject_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (take),
    .push_data (eject_data),
    .pop       (eject_ack),
    .head      (eject_packet),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign eject_valid = ~fifo_empty;

`ifdef RING_STOP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_injected    <= '0;
      stat_ejected     <= '0;
      stat_bypass_full <= '0;
      stat_wait_cycles <= '0;
    end else begin
      stat_injected    <= stat_injected    + 32'(issuing & ~inj_empty);
      stat_ejected     <= stat_ejected     + 32'(take);
      stat_bypass_full <= stat_bypass_full + 32'(hit & fifo_full);
      stat_wait_cycles <= stat_wait_cycles + 32'(state == S_WAIT);
    end
  end
`endif

endmodule

// File: tb/tb_ring_stop.sv
// Self-checking bench for ring_stop (STOP_ID=1, NUM_STOPS=4, EJECT_DEPTH=4):
// directed scenarios then random traffic against a queue-based reference model.
module tb_ring_stop;
  import ring_stop_pkg::*;

  localparam int unsigned STOP_ID   = 1;
  localparam int unsigned NUM_STOPS = 4;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CHK_W     = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue;
  ring_packet packet;
  logic       issuing;
  logic       ready;
  ring_packet ring_in;
  ring_packet ring_out;
  logic       eject_valid;
  ring_packet eject_packet;
  logic       eject_ack;
`ifdef RING_STOP_STATS_EN
  logic [31:0] stat_injected, stat_ejected, stat_bypass_full, stat_wait_cycles;
`endif

  ring_stop #(
    .STOP_ID     (STOP_ID),
    .NUM_STOPS   (NUM_STOPS),
    .EJECT_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .issue            (issue),
    .packet           (packet),
    .issuing          (issuing),
    .ready            (ready),
    .ring_in          (ring_in),
    .ring_out         (ring_out),
    .eject_valid      (eject_valid),
    .eject_packet     (eject_packet),
`ifdef RING_STOP_STATS_EN
    .stat_injected    (stat_injected),
    .stat_ejected     (stat_ejected),
    .stat_bypass_full (stat_bypass_full),
    .stat_wait_cycles (stat_wait_cycles),
`endif
    .eject_ack        (eject_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [CHK_W-1:0] got, input logic [CHK_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: ejection queue, outstanding-request flag, expected ring_out.
  ring_packet  fifo_q[$];
  bit          waiting;
  ring_packet  exp_out;
  int unsigned n_inj, n_ej, n_byp, n_wait;

  function automatic ring_packet make_pkt(input logic [31:0] dest);
    ring_packet p;
    p.valid       = 1'b1;
    p.kind        = ring_packet_kind_t'($urandom_range(0, 3));
    p.sender_id   = core_id_t'($urandom_range(0, NUM_STOPS - 1));
    p.dest_vector = dest;
    p.address     = RING_ADDR_W'({$urandom, $urandom});
    p.data        = {$urandom, $urandom};
    return p;
  endfunction

  // One cycle: drive at negedge, check outputs, then advance the model to the next edge.
  task automatic step(input logic rst, input logic iss, input ring_packet pk,
                      input ring_packet rin, input logic ack, output bit acc);
    bit          hit, room;
    ring_packet  fwd, stamped;
    logic [31:0] mdest;
    @(negedge clk);
    reset = rst; issue = iss; packet = pk; ring_in = rin; eject_ack = ack;
    #1;
    check("ring_out.valid", 256'(ring_out.valid), 256'(exp_out.valid));
    if (exp_out.valid) check("ring_out", 256'(ring_out), 256'(exp_out));

    hit  = rin.valid && ((rin.dest_vector >> STOP_ID) & 32'd1) != 0;
    room = fifo_q.size() < DEPTH;
    fwd  = rin;
    if (hit && room) fwd.dest_vector = rin.dest_vector & ~(32'd1 << STOP_ID);
    if (fwd.dest_vector == 0) fwd.valid = 1'b0;
    acc   = !rst && iss && !fwd.valid;
    mdest = pk.dest_vector & ((32'd1 << NUM_STOPS) - 32'd1) & ~(32'd1 << STOP_ID);

    check("issuing", 256'(issuing), 256'(acc));
    check("ready", 256'(ready), 256'(rst || (!waiting && !acc)));
    check("eject_valid", 256'(eject_valid), 256'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) check("eject_packet", 256'(eject_packet), 256'(fifo_q[0]));
`ifdef RING_STOP_STATS_EN
    check("stat_injected", 256'(stat_injected), 256'(n_inj));
    check("stat_ejected", 256'(stat_ejected), 256'(n_ej));
    check("stat_bypass_full", 256'(stat_bypass_full), 256'(n_byp));
    check("stat_wait_cycles", 256'(stat_wait_cycles), 256'(n_wait));
`endif

    if (rst) begin
      fifo_q.delete();
      waiting = 0;
      exp_out = '0;
      n_inj = 0; n_ej = 0; n_byp = 0; n_wait = 0;
    end else begin
      if (waiting) n_wait++;
      if (hit && !room) n_byp++;
      if (ack && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (hit && room) begin
        ring_packet e;
        e = rin;
        e.dest_vector = 32'd1 << STOP_ID;
        fifo_q.push_back(e);
        n_ej++;
      end
      waiting = iss && !acc;
      if (acc && mdest != 0) begin
        stamped             = pk;
        stamped.valid       = 1'b1;
        stamped.sender_id   = core_id_t'(STOP_ID);
        stamped.dest_vector = mdest;
        exp_out             = stamped;
        n_inj++;
      end else begin
        exp_out = fwd;
      end
    end
  endtask

  initial begin
    ring_packet idle, pk, rin;
    bit acc, pend;
    int phase;
    idle = '0;
    reset = 1'b1; issue = 1'b0; packet = '0; ring_in = '0; eject_ack = 1'b0;
    repeat (2) @(posedge clk);
    fifo_q.delete(); waiting = 0; exp_out = '0;
    n_inj = 0; n_ej = 0; n_byp = 0; n_wait = 0;

    // Reset state held for a cycle.
    step(1, 0, idle, idle, 0, acc);
    // Idle-ring injection to stop 2.
    pk = make_pkt(32'h4);
    step(0, 1, pk, idle, 0, acc);
    step(0, 0, idle, idle, 0, acc);
    // Hit on 0x6: eject our copy, forward 0x4.
    step(0, 0, idle, make_pkt(32'h6), 0, acc);
    step(0, 0, idle, idle, 1, acc);
    // Busy slot puts request in WAIT; a consumed 0x2 packet frees the slot.
    pk = make_pkt(32'h9);
    step(0, 1, pk, make_pkt(32'h4), 0, acc);
    step(0, 1, pk, make_pkt(32'h2), 0, acc);
    step(0, 0, idle, idle, 1, acc);
    // Five busy cycles with issue held, then the first free slot.
    pk = make_pkt(32'hD);
    for (int i = 0; i < 5; i++) step(0, 1, pk, make_pkt(32'h8), 0, acc);
    step(0, 1, pk, idle, 0, acc);
    step(0, 0, idle, idle, 0, acc);
    // Fill the FIFO, then a fifth hit must bypass with bit 1 still set.
    for (int i = 0; i < 5; i++) step(0, 0, idle, make_pkt(32'h2), 0, acc);
    step(0, 0, idle, make_pkt(32'h2), 1, acc);
    for (int i = 0; i < 5; i++) step(0, 0, idle, idle, 1, acc);
    // Self-only destination: pulses issuing, injects nothing.
    pk = make_pkt(32'h2);
    step(0, 1, pk, idle, 0, acc);
    step(0, 0, idle, idle, 0, acc);
    // Reset while waiting drops the request.
    pk = make_pkt(32'h1);
    step(0, 0, idle, make_pkt(32'h2), 0, acc);
    step(0, 1, pk, make_pkt(32'h8), 0, acc);
    step(1, 1, pk, make_pkt(32'h8), 0, acc);
    step(0, 0, idle, idle, 0, acc);

    // Random traffic in phases of varying ring load and consumer speed.
    pend = 0;
    pk   = idle;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit rst;
      phase = (cyc / 250) % 4;
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1;
        pk   = make_pkt($urandom);
      end
      if ($urandom_range(0, 99) < (phase == 1 ? 90 : 45))
        rin = make_pkt(32'($urandom_range(1, 15)));
      else
        rin = idle;
      rst = ($urandom_range(0, 299) == 0);
      step(rst, pend, pend ? pk : idle, rin,
           ($urandom_range(0, 99) < (phase == 2 ? 5 : 60)), acc);
      if (acc || rst) pend = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_stop.md
Name: ring_stop

Overview:
- One stop on the ring NoC (snoop, IPI or L2-miss ring).
- Acts as the receiver_side of ring_if for a local packet generator: accepts `issue`/`packet` and injects into a free ring slot.
- Forwards ring traffic through a one-cycle register stage.
- Ejects packets whose dest_vector targets this stop into a local FIFO for the consumer.

Parameters:
- STOP_ID, 0, index of this stop; selects its bit in dest_vector and is stamped into sender_id.
- NUM_STOPS, 4, number of stops on the ring (1..32); dest_vector bits at or above NUM_STOPS are masked at injection.
- EJECT_DEPTH, 4, ejection FIFO depth; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue  in  1  ring_if receiver_side: local issuer requests injection.
- packet  in  ring_packet  ring_if receiver_side: packet to inject.
- issuing  out  1  ring_if receiver_side: packet accepted this cycle.
- ready  out  1  ring_if receiver_side: stop idle and ready for next request.
- ring_in  in  ring_packet  packet from the upstream stop's ring_out.
- ring_out  out  ring_packet  registered packet to the downstream stop.
- eject_valid  out  1  ejection FIFO non-empty.
- eject_packet  out  ring_packet  FIFO head; dest_vector shows only the STOP_ID bit.
- eject_ack  in  1  pop FIFO head; ignored when empty.

Behaviour:
- Reset:
  - ring_out all zero (valid=0); issuing=0; ready=1; eject_valid=0.
  - FIFO flushed; FSM to IDLE.
  - Reset mid-injection drops the pending packet with no issuing pulse.
- Ring path, each cycle, from ring_in:
  - hit = ring_in.valid & dest_vector[STOP_ID].
  - If hit and FIFO not full at cycle start: push a copy (dest_vector reduced to the STOP_ID bit) and clear the STOP_ID bit in the forwarded copy.
  - If hit and FIFO full: bit is not cleared; packet continues round the ring and retries next lap.
  - Forwarded copy with dest_vector==0 frees the slot (valid=0).
  - Otherwise forwarded unchanged.
  - ring_out <= slot result, or the injected packet (below). Pass-through latency is exactly 1 cycle.
- Slot free: ring_in.valid==0, or the packet is fully consumed this cycle.
- FSM:
  - IDLE (ready=1):
    - issue & slot free → issuing=1 combinationally in the same cycle; injected packet goes to ring_out next edge; next state DONE.
    - issue & slot busy → WAIT.
  - WAIT (ready=0): issuing asserts the first cycle the slot is free; next state DONE. Issuer holds packet and issue stable until issuing.
  - DONE (ready=1): behaves exactly as IDLE. The state exists only to mark that ready rises the cycle after issuing and stays high until the next issue.
- ready is 0 only in WAIT and on the cycle a request is accepted.
- Injection stamping:
  - valid forced to 1; sender_id = STOP_ID.
  - dest_vector masked to bits [NUM_STOPS-1:0] and the STOP_ID bit cleared (no self-delivery).
  - All other fields pass through.
- Masked dest_vector==0: issuing still pulses and ready behaves normally, but nothing is injected; the slot stays as computed.
- Pass-through traffic always has priority over injection; injection never displaces a valid packet.
- FIFO:
  - Push and pop in the same cycle are both honoured.
  - Full is evaluated before the pop, so a full FIFO with eject_ack still refuses that cycle's push.
  - eject_packet is stable while eject_valid & !eject_ack.

Optional Feature:
- Macro RING_STOP_STATS_EN.
- Defined: adds outputs stat_injected, stat_ejected, stat_bypass_full, stat_wait_cycles (32-bit each).
  - stat_injected: accepted non-empty injections.
  - stat_ejected: FIFO pushes.
  - stat_bypass_full: hits refused because the FIFO was full.
  - stat_wait_cycles: cycles spent in WAIT.
  - Counters wrap at 2^32 and are zeroed on reset.
- Not defined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package: ring_packet, RING_PACKET_KIND, core_id_t, CACHE_LINE_BYTES, plus a new RING_MAX_STOPS=32 constant.
- Sub-module ring_eject_fifo (parameterised depth; push/pop/full/empty; synchronous reset).
- ring_stop owns the slot logic and the FSM.

Test Plan:
- STOP_ID=1, idle ring; issue with dest_vector=0x4 → issuing=1 same cycle, ready=0 that cycle, ready=1 next; ring_out.valid=1, sender_id=1, dest_vector=0x4 one cycle later.
- ring_in valid, dest_vector=0x6, STOP_ID=1, FIFO empty → eject_valid=1 next cycle with dest_vector 0x2; ring_out dest_vector=0x4.
- ring_in valid, dest_vector=0x2 while issue pending → packet ejected, slot freed, issuing=1 that cycle, injected packet on ring_out next cycle.
- Continuous valid non-hit ring_in for 5 cycles with issue held → ready=0 and issuing=0 for 5 cycles; injection on the first free cycle.
- FIFO filled to EJECT_DEPTH=4, 5th hit dest_vector=0x2 → not ejected, ring_out keeps bit 1 set; with RING_STOP_STATS_EN, stat_bypass_full=1.
- Issue with dest_vector=0x2 at STOP_ID=1 (self only) → issuing pulses, ring_out.valid stays 0; reset asserted in WAIT → next cycle ready=1, issuing=0, FIFO empty.
